// File: rtl/bfp_seq.sv
// Sequential body-fat estimator: BMI via restoring divide, linear fit, second divide, category.
// Optional BFP_SEQ_ERR_EN adds an err port and a zero-height short-cut to DONE.
module bfp_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] weight,
   input  logic [W-1:0] height,
   input  logic [W-1:0] age,
   input  logic         sex,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] bfp,
`ifdef BFP_SEQ_ERR_EN
   output logic         err,
`endif
   output logic [2:0]   bfprange
);

   localparam int NW = W + 14;
   localparam int DW = 2 * W;
   localparam int CW = $clog2(NW + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_DIV1  = 3'd2;
   localparam logic [2:0] S_LIN   = 3'd3;
   localparam logic [2:0] S_DIV2  = 3'd4;
   localparam logic [2:0] S_CLASS = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

   logic [2:0]    state;
   logic [W-1:0]  w_r, h_r, a_r;
   logic          s_r;
   logic [NW-1:0] num, quo;
   logic [DW-1:0] den, rem;
   logic [CW-1:0] cnt;

   logic [DW:0]   rsh;
   logic [DW-1:0] diff;
   logic          ge;
   logic [W-1:0]  qsat;
   int            p_int;
   logic [NW-1:0] p_c;

   // One restoring step; an explicit compare keeps a zero divisor producing all-ones.
   always_comb begin
      rsh   = {rem, num[NW-1]};
      ge    = (rsh >= {1'b0, den});
      diff  = rsh[DW-1:0] - den;
      qsat  = (|quo[NW-1:W]) ? {W{1'b1}} : quo[W-1:0];
      p_int = 120 * int'(qsat) + 23 * int'(a_r) - (s_r ? 1080 : 0) - 540;
      p_c   = (p_int < 0) ? '0 : NW'(p_int);
   end

   function automatic logic [2:0] classify(input logic [W-1:0] v, input logic male);
      int b;
      b = int'(v);
      if (male) begin
         if (b < 6)       return 3'd0;
         else if (b < 14) return 3'd1;
         else if (b < 18) return 3'd2;
         else if (b < 25) return 3'd3;
         else             return 3'd4;
      end else begin
         if (b < 14)      return 3'd0;
         else if (b < 21) return 3'd1;
         else if (b < 25) return 3'd2;
         else if (b < 32) return 3'd3;
         else             return 3'd4;
      end
   endfunction

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         w_r      <= '0;
         h_r      <= '0;
         a_r      <= '0;
         s_r      <= 1'b0;
         num      <= '0;
         quo      <= '0;
         den      <= '0;
         rem      <= '0;
         cnt      <= '0;
         bfp      <= '0;
         bfprange <= '0;
`ifdef BFP_SEQ_ERR_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               w_r   <= weight;
               h_r   <= height;
               a_r   <= age;
               s_r   <= sex;
               state <= S_PREP;
            end
            S_PREP: begin
               num <= NW'(w_r) * NW'(10000);
               den <= DW'(h_r) * DW'(h_r);
               rem <= '0;
               quo <= '0;
               cnt <= CW'(NW - 1);
`ifdef BFP_SEQ_ERR_EN
               if (h_r == '0) state <= S_ERR;
               else           state <= S_DIV1;
`else
               state <= S_DIV1;
`endif
            end
            S_DIV1, S_DIV2: begin
               rem <= ge ? diff : rsh[DW-1:0];
               num <= num << 1;
               quo <= {quo[NW-2:0], ge};
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= (state == S_DIV1) ? S_LIN : S_CLASS;
            end
            // p is left-aligned so the shorter second divide still walks from the MSB.
            S_LIN: begin
               num   <= p_c << 2;
               den   <= DW'(100);
               rem   <= '0;
               quo   <= '0;
               cnt   <= CW'(W + 11);
               state <= S_DIV2;
            end
            S_CLASS: begin
               bfp      <= qsat;
               bfprange <= classify(qsat, s_r);
`ifdef BFP_SEQ_ERR_EN
               err      <= 1'b0;
`endif
               state    <= S_DONE;
            end
            S_ERR: begin
               bfp      <= '0;
               bfprange <= 3'd7;
`ifdef BFP_SEQ_ERR_EN
               err      <= 1'b1;
`endif
               state    <= S_DONE;
            end
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bfp_seq.sv
// Scoreboard bench for bfp_seq: driver pushes expected results, monitor pops on out_valid.
module tb_bfp_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] weight = '0, height = '0, age = '0;
   logic       sex = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] bfp;
   logic [2:0] bfprange;
`ifdef BFP_SEQ_ERR_EN
   logic       err;
`endif

   bfp_seq #(.W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .weight(weight), .height(height), .age(age), .sex(sex),
      .out_valid(out_valid), .out_ready(out_ready), .bfp(bfp),
`ifdef BFP_SEQ_ERR_EN
      .err(err),
`endif
      .bfprange(bfprange)
   );

   always #5 clk = ~clk;

   typedef struct {
      int eb;
      int er;
      int ee;
      int lat;
      int acc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   prev_ov = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor: compare on every rising out_valid.
   always @(negedge clk) begin
      if (out_valid && !prev_ov) begin
         if (sbq.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("bfp", int'(bfp), e.eb);
            chk("bfprange", int'(bfprange), e.er);
            chk("latency", cyc - e.acc, e.lat);
`ifdef BFP_SEQ_ERR_EN
            chk("err", int'(err), e.ee);
`endif
         end
      end
      prev_ov = out_valid;
   end

   task automatic send(input int w, input int h, input int a, input bit s,
                       input int eb, input int er, input int ee, input int lat);
      int   t;
      exp_t e;
      @(negedge clk);
      weight = 8'(w); height = 8'(h); age = 8'(a); sex = s;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.eb = eb; e.er = er; e.ee = ee; e.lat = lat; e.acc = cyc;
      sbq.push_back(e);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 300) begin @(negedge clk); t++; end
      if (sbq.size() != 0) begin
         chk("result_timeout", int'(sbq.size()), 0);
         sbq.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : main
      int  t;
      bit  seen;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_bfp", int'(bfp), 0);
      chk("rst_bfprange", int'(bfprange), 0);
      rst_n = 1'b1;

      // Directed vectors: w, h, age, sex -> bfp, range, err, latency
      send(80, 170, 24, 0, 32, 4, 0, 45); drain();
      chk("retain_bfp_idle", int'(bfp), 32);
      chk("retain_range_idle", int'(bfprange), 4);
      send(80, 170, 24, 1, 21, 3, 0, 45); drain();
      send(50, 200, 20, 1,  2, 0, 0, 45); drain();
      send(50, 200, 20, 0, 13, 0, 0, 45); drain();
      send(40, 200,  0, 1,  0, 0, 0, 45); drain();
      send(50, 200, 22, 0, 14, 1, 0, 45); drain();
      send(80, 170, 39, 1, 25, 4, 0, 45); drain();
      send(50, 200, 34, 1,  6, 1, 0, 45); drain();
`ifdef BFP_SEQ_ERR_EN
      send(80,   0,  0, 0,  0, 7, 1,  2); drain();
      send(80, 170, 24, 0, 32, 4, 0, 45); drain();
`else
      send(80,   0,  0, 0, 255, 4, 0, 45); drain();
`endif

      // Backpressure: result held, second request ignored.
      out_ready = 1'b0;
      send(80, 170, 24, 0, 32, 4, 0, 45);
      t = 0;
      while (!out_valid && t < 100) begin @(negedge clk); t++; end
      chk("hold_reached", int'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) begin
            weight = 8'd50; height = 8'd200; age = 8'd20; sex = 1'b1;
            in_valid = 1'b1;
         end
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_bfp", int'(bfp), 32);
         chk("hold_range", int'(bfprange), 4);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", int'(out_valid), 0);
      chk("release_in_ready", int'(in_ready), 1);
      @(negedge clk);
      chk("no_second_accept", int'(in_ready), 1);
      chk("hold_queue_empty", int'(sbq.size()), 0);

      // Reset mid-computation: request discarded, no result follows.
      send(80, 170, 24, 0, 32, 4, 0, 45);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_bfp", int'(bfp), 0);
      if (sbq.size() != 0) void'(sbq.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_output", int'(seen), 0);
      send(50, 200, 20, 0, 13, 0, 0, 45); drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
